mips_alu_seq: RTL and testbench

Parametrised multi-cycle successor to the single-cycle MIPS ALU. It adds a registered start/done handshake, iterative unsigned multiply and divide with HI/LO result registers, logic and set-less-than operations, and zero and divide-by-zero flags. It sits in the EX stage of the MIPS datapath. The pipeline stalls on `busy` while a MUL or DIV iterates.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/mips_alu_seq_muldiv_iter.sv | 64 ++++++
 rtl/mips_alu_seq.sv | 136 +++++++++++++
 tb/tb_mips_alu_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS ALU: opcode encodings and FSM states.
package mips_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0011;
   localparam logic [3:0] ALU_MUL = 4'b0100;
   localparam logic [3:0] ALU_DIV = 4'b0101;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // True for the opcodes that run through the iterative multiply/divide unit.
   function automatic logic is_iter(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_DIV);
   endfunction

endpackage

// File: rtl/mips_alu_seq_muldiv_iter.sv
// Shared 2*WIDTH accumulator for unsigned shift-add multiply and restoring divide.
// Upper half ends as product-high / remainder, lower half as product-low / quotient.
module muldiv_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 step,
   input  logic                 mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   acc_next,
   output logic [CNT_W-1:0]     count
);

   logic [2*WIDTH-1:0] acc_r;
   logic [WIDTH-1:0]   opnd_r;
   logic [CNT_W-1:0]   count_r;
   logic [WIDTH:0]     sum_s;
   logic [WIDTH:0]     rem_shift_s;
   logic [WIDTH:0]     diff_s;

   // One iteration: mode 0 adds the multiplicand then shifts right,
   // mode 1 shifts the remainder left and keeps the trial subtraction if it fits.
   always_comb begin
      sum_s       = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? opnd_r : {WIDTH{1'b0}})};
      rem_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
      diff_s      = rem_shift_s - {1'b0, opnd_r};
      if (mode) begin
         if (!diff_s[WIDTH]) begin
            acc_next = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {rem_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_next = {sum_s, acc_r[WIDTH-1:1]};
      end
   end

   // Accumulator, operand and iteration counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r   <= {(2*WIDTH){1'b0}};
         opnd_r  <= {WIDTH{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else if (load) begin
         acc_r   <= {{WIDTH{1'b0}}, a};
         opnd_r  <= b;
         count_r <= CNT_W'(WIDTH);
      end else if (step) begin
         acc_r   <= acc_next;
         count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         acc_r   <= acc_r;
         opnd_r  <= opnd_r;
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/mips_alu_seq.sv
// Multi-cycle MIPS EX-stage ALU with start/done handshake, HI/LO registers,
// zero and divide-by-zero flags.
module mips_alu_seq
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       controlLines,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             zero,
   output logic             div_by_zero
);

   state_t             state_r;
   logic [3:0]         op_r;
   logic               bzero_r;
   logic               busy_r;
   logic               done_r;
   logic [WIDTH-1:0]   out_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               zero_r;
   logic               dbz_r;
   logic [WIDTH-1:0]   alu_s;
   logic               load_s;
   logic               step_s;
   logic [2*WIDTH-1:0] acc_next_s;
   logic [CNT_W-1:0]   count_s;

   assign load_s = (state_r == IDLE) && start && is_iter(controlLines);
   assign step_s = (state_r == RUN);

   muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
      .clk      (clk),
      .reset    (reset),
      .load     (load_s),
      .step     (step_s),
      .mode     (op_r == ALU_DIV),
      .a        (a),
      .b        (b),
      .acc_next (acc_next_s),
      .count    (count_s)
   );

   // Single-cycle datapath; MUL/DIV and unused codes produce zero here.
   always_comb begin
      case (controlLines)
         ALU_AND: alu_s = a & b;
         ALU_OR:  alu_s = a | b;
         ALU_ADD: alu_s = a + b;
         ALU_SUB: alu_s = a - b;
         ALU_SLT: alu_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: alu_s = {WIDTH{1'b0}};
      endcase
   end

   // Control FSM with registered result, HI/LO and flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         op_r    <= 4'b0000;
         bzero_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         out_r   <= {WIDTH{1'b0}};
         hi_r    <= {WIDTH{1'b0}};
         lo_r    <= {WIDTH{1'b0}};
         zero_r  <= 1'b1;
         dbz_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  op_r    <= controlLines;
                  bzero_r <= (b == {WIDTH{1'b0}});
                  dbz_r   <= 1'b0;
                  if (is_iter(controlLines)) begin
                     busy_r  <= 1'b1;
                     state_r <= RUN;
                  end else begin
                     out_r   <= alu_s;
                     zero_r  <= (alu_s == {WIDTH{1'b0}});
                     done_r  <= 1'b1;
                     state_r <= DONE;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               // Last iteration: both modes leave {hi, lo} in the accumulator.
               if (count_s == CNT_W'(1)) begin
                  hi_r    <= acc_next_s[2*WIDTH-1:WIDTH];
                  lo_r    <= acc_next_s[WIDTH-1:0];
                  out_r   <= acc_next_s[WIDTH-1:0];
                  zero_r  <= (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
                  dbz_r   <= (op_r == ALU_DIV) && bzero_r;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  state_r <= RUN;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign out         = out_r;
   assign hi          = hi_r;
   assign lo          = lo_r;
   assign zero        = zero_r;
   assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_mips_alu_seq.sv
// Directed self-checking bench for mips_alu_seq at WIDTH=32.
module tb_mips_alu_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  controlLines;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] out;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        zero;
   logic        div_by_zero;

   int checks;
   int failures;

   mips_alu_seq #(.WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .controlLines (controlLines),
      .a            (a),
      .b            (b),
      .busy         (busy),
      .done         (done),
      .out          (out),
      .hi           (hi),
      .lo           (lo),
      .zero         (zero),
      .div_by_zero  (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request for exactly one edge; returns in cycle 1 after that edge.
   task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      controlLines = op;
      a            = x;
      b            = y;
      start        = 1'b1;
      tick();
      start        = 1'b0;
   endtask

   // Called in cycle 1 of a MUL/DIV; checks busy over cycles 1..32, returns in cycle 33.
   task automatic wait_iter(input string tag);
      int bad;
      bad = 0;
      for (int i = 1; i <= 32; i++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad++;
         tick();
      end
      chk({tag, "_busy_window"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int n;
      checks       = 0;
      failures     = 0;
      reset        = 1'b1;
      start        = 1'b0;
      controlLines = 4'b0000;
      a            = 32'd0;
      b            = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out", out, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);

      // ADD wrap
      run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
      chk("add_done", 32'(done), 32'd1);
      chk("add_out", out, 32'd0);
      chk("add_zero", 32'(zero), 32'd1);
      chk("add_busy", 32'(busy), 32'd0);
      tick();
      chk("add_done_pulse", 32'(done), 32'd0);

      run_op(4'b0011, 32'd5, 32'd7);
      chk("sub_out", out, 32'hFFFF_FFFE);
      chk("sub_zero", 32'(zero), 32'd0);
      tick();
      run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
      chk("and_out", out, 32'hF000_F000);
      tick();
      run_op(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00);
      chk("or_out", out, 32'hFFF0_FFF0);
      tick();
      run_op(4'b1111, 32'd5, 32'd3);
      chk("unk_done", 32'(done), 32'd1);
      chk("unk_out", out, 32'd0);
      chk("unk_zero", 32'(zero), 32'd1);
      tick();

      // MUL 0xFFFFFFFF * 2
      run_op(4'b0100, 32'hFFFF_FFFF, 32'd2);
      wait_iter("mul");
      chk("mul_done", 32'(done), 32'd1);
      chk("mul_busy_fall", 32'(busy), 32'd0);
      chk("mul_hi", hi, 32'h0000_0001);
      chk("mul_lo", lo, 32'hFFFF_FFFE);
      chk("mul_out", out, 32'hFFFF_FFFE);
      chk("mul_zero", 32'(zero), 32'd0);
      tick();

      // DIV 100 / 7, then SLT leaves HI/LO alone
      run_op(4'b0101, 32'd100, 32'd7);
      wait_iter("div");
      chk("div_done", 32'(done), 32'd1);
      chk("div_lo", lo, 32'd14);
      chk("div_out", out, 32'd14);
      chk("div_hi", hi, 32'd2);
      chk("div_dbz", 32'(div_by_zero), 32'd0);
      tick();
      run_op(4'b0111, 32'hFFFF_FFFF, 32'd0);
      chk("slt_out", out, 32'd1);
      chk("slt_hi_kept", hi, 32'd2);
      chk("slt_lo_kept", lo, 32'd14);
      tick();
      run_op(4'b0111, 32'd3, 32'hFFFF_FFFF);
      chk("slt_false_out", out, 32'd0);
      tick();

      // DIV by zero
      run_op(4'b0101, 32'h0000_1234, 32'd0);
      wait_iter("div0");
      chk("div0_done", 32'(done), 32'd1);
      chk("div0_out", out, 32'hFFFF_FFFF);
      chk("div0_lo", lo, 32'hFFFF_FFFF);
      chk("div0_hi", hi, 32'h0000_1234);
      chk("div0_dbz", 32'(div_by_zero), 32'd1);
      tick();
      chk("div0_dbz_held", 32'(div_by_zero), 32'd1);
      run_op(4'b0010, 32'd3, 32'd4);
      chk("dbz_cleared", 32'(div_by_zero), 32'd0);
      chk("add2_out", out, 32'd7);
      tick();

      // Start held high: single-cycle ops accept every other cycle
      controlLines = 4'b0010;
      a            = 32'd1;
      b            = 32'd1;
      start        = 1'b1;
      n            = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done === 1'b1) n++;
      end
      start = 1'b0;
      chk("throughput_dones", 32'(n), 32'd2);
      chk("throughput_out", out, 32'd2);

      // MUL with ignored start pulses at cycles 5 and 33
      run_op(4'b0100, 32'd3, 32'd5);
      n = 0;
      for (int c = 1; c <= 32; c++) begin
         if (busy !== 1'b1 || done !== 1'b0) n++;
         if (c == 5) begin
            controlLines = 4'b0010;
            a            = 32'd100;
            b            = 32'd200;
            start        = 1'b1;
         end
         tick();
         start = 1'b0;
      end
      chk("ign_busy_window", 32'(n), 32'd0);
      chk("ign_done", 32'(done), 32'd1);
      chk("ign_out", out, 32'd15);
      chk("ign_hi", hi, 32'd0);
      chk("ign_lo", lo, 32'd15);
      controlLines = 4'b0010;
      a            = 32'd100;
      b            = 32'd200;
      start        = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) n++;
         tick();
      end
      chk("ign_no_second_done", 32'(n), 32'd0);
      chk("ign_out_kept", out, 32'd15);

      // Reset mid-RUN aborts the MUL
      run_op(4'b0100, 32'd7, 32'd6);
      for (int c = 1; c < 10; c++) tick();
      chk("abort_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_out", out, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      chk("abort_zero", 32'(zero), 32'd1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) n++;
         tick();
      end
      chk("abort_no_done", 32'(n), 32'd0);

      run_op(4'b0100, 32'd7, 32'd6);
      wait_iter("mul76");
      chk("mul76_done", 32'(done), 32'd1);
      chk("mul76_lo", lo, 32'd42);
      chk("mul76_hi", hi, 32'd0);
      chk("mul76_out", out, 32'd42);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
